// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity encodings and the
// bit-divisor helper used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per serial bit; callers subtract 1 for a 0-based terminal count.
  function automatic int uart_bit_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter. It counts 0..BIT_CNT_MAX while run_i is high
// and flags the mid-bit (half_o) and end-of-period (tick_o) counts.
module uart_baud_tick #(
  parameter int BIT_CNT_MAX = 9,
  parameter int HALF_CNT    = BIT_CNT_MAX / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic restart_i,
  output logic tick_o,
  output logic half_o
);

  localparam int CW = $clog2(BIT_CNT_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(BIT_CNT_MAX));
  assign half_o = (cnt_q == CW'(HALF_CNT));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!run_i || restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl_module.sv
// UART receiver: synchronises rxd, verifies the start bit at mid-bit,
// deserialises LSB-first, checks parity/stop and hands bytes out via valid/ready.
module uart_rx_ctrl_module
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = PAR_NONE,
  parameter int BIT_CNT_MAX = uart_bit_div(CLK_FREQ, BAUD_RATE) - 1,
  parameter int HALF_CNT    = BIT_CNT_MAX / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS);

  rx_state_e            state_q;
  logic                 sync1_q;
  logic                 rxd_s_q;
  logic                 rxd_prev_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;

  logic fall_edge;
  logic bit_tick;
  logic half_tick;
  logic exp_par;

  assign fall_edge = !rxd_s_q && rxd_prev_q;
  assign exp_par   = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_baud_tick #(
    .BIT_CNT_MAX (BIT_CNT_MAX),
    .HALF_CNT    (HALF_CNT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .run_i     (state_q != ST_IDLE),
    .restart_i ((state_q == ST_START) && half_tick),
    .tick_o    (bit_tick),
    .half_o    (half_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      rxd_s_q    <= sync1_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (fall_edge) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (half_tick) begin
            state_q <= rxd_s_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift_q <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            par_bad_q <= (rxd_s_q != exp_par);
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at the mid-stop sample so a back-to-back start edge is caught.
          if (bit_tick) begin
            state_q   <= ST_IDLE;
            par_bad_q <= 1'b0;
            if (!rxd_s_q) begin
              frame_err_q <= 1'b1;
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
